fb_arbiter: RTL and testbench

Single-port frame-buffer arbiter and pixel fetch scheduler between the camera write path and the 640x480 VGA timing generator. Each pclk cycle it owns the one memory port and grants it either to the display fetch, which has fixed priority, or to a pending camera write. It stores a 320x240 RGB444 image and pixel-doubles it onto the 640x480 display. It also delays the timing generator's sync and valid so they line up with the fetched pixel data.

---
 rtl/fb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter
//
// Single-port frame-buffer arbiter and pixel fetch scheduler. Every pclk
// cycle the one memory port goes either to the display fetch (fixed
// priority) or to a pending camera write. A 320x240 RGB444 image is stored
// and pixel-doubled onto a 640x480 display; the timing generator's syncs
// and valid are delayed so they line up with the fetched pixel.
//
// Ports:
//   pclk, reset              pixel clock, asynchronous active-high reset
//   h_cnt, v_cnt             display column/line from the timing generator
//   valid_in                 active-video flag
//   hsync_in, vsync_in       active-low syncs
//   wr_req/wr_addr/wr_data   camera write request (held until wr_ack)
//   wr_ack                   one-cycle pulse when the request is consumed
//   wr_drop                  sticky: an out-of-range write was discarded
//   mem_addr/mem_we/mem_wdata registered memory port
//   mem_rdata                synchronous read data, 1 cycle after mem_addr
//   rgb                      display pixel, 0 outside active video
//   hsync, vsync, valid      inputs delayed by 3 cycles
//   arb_state                slot decision that produced the current port outputs
//
// Handshake: the camera raises wr_req with wr_addr/wr_data and keeps all
// three stable until it sees wr_ack=1. wr_ack is high in the same cycle the
// write appears on mem_we/mem_addr; the camera may change its request in the
// following cycle. Because the camera only sees the ack one cycle late, no
// new grant is made while wr_ack is high, so a still-held request is never
// written twice.

module fb_arbiter #(
  parameter int FB_W = 320,
  parameter int FB_H = 240,
  parameter int AW   = 17,
  parameter int DW   = 12
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          valid_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_drop,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rgb,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [1:0]    arb_state
);

  localparam logic [AW-1:0] FB_SIZE = AW'(FB_W * FB_H);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_SLOT  = 2'd1,
    ST_WR_GRANT = 2'd2
  } arb_state_e;

  arb_state_e    state_d, state_q;
  logic [AW-1:0] mem_addr_d, mem_addr_q;
  logic          mem_we_d, mem_we_q;
  logic [DW-1:0] mem_wdata_d, mem_wdata_q;
  logic          wr_ack_d, wr_ack_q;
  logic          wr_drop_d, wr_drop_q;
  // rd_p1 marks that mem_addr holds a fetch, rd_p2 that mem_rdata holds it
  logic          rd_p1_d, rd_p1_q;
  logic          rd_p2_d, rd_p2_q;
  logic [DW-1:0] pix_d, pix_q;
  logic [2:0]    hs_sr_d, hs_sr_q;
  logic [2:0]    vs_sr_d, vs_sr_q;
  logic [2:0]    vld_sr_d, vld_sr_q;

  logic          rd_slot;
  logic [AW-1:0] v_half, h_half, rd_addr;
  logic          unused_v_lsb;

  // Even active columns fetch; odd columns reuse the same word, so they and
  // all blanking cycles are free for camera writes.
  assign rd_slot = valid_in & ~h_cnt[0];

  // (v>>1)*320 as (v>>1)*256 + (v>>1)*64: two shifts and an adder.
  assign v_half  = AW'(v_cnt[9:1]);
  assign h_half  = AW'(h_cnt[9:1]);
  assign rd_addr = (v_half << 8) + (v_half << 6) + h_half;

  // Line doubling drops the LSB of the line number.
  assign unused_v_lsb = v_cnt[0];

  always_comb begin
    state_d     = ST_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    wr_ack_d    = 1'b0;
    wr_drop_d   = wr_drop_q;

    if (rd_slot) begin
      state_d    = ST_RD_SLOT;
      mem_addr_d = rd_addr;
    end else if (wr_req && !wr_ack_q) begin
      state_d  = ST_WR_GRANT;
      wr_ack_d = 1'b1;
      if (wr_addr < FB_SIZE) begin
        mem_addr_d  = wr_addr;
        mem_we_d    = 1'b1;
        mem_wdata_d = wr_data;
      end else begin
        // Consumed but discarded; the flag stays up until reset.
        wr_drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    rd_p1_d  = rd_slot;
    rd_p2_d  = rd_p1_q;
    pix_d    = rd_p2_q ? mem_rdata : pix_q;
    hs_sr_d  = {hs_sr_q[1:0], hsync_in};
    vs_sr_d  = {vs_sr_q[1:0], vsync_in};
    vld_sr_d = {vld_sr_q[1:0], valid_in};
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      wr_drop_q   <= 1'b0;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      pix_q       <= '0;
      hs_sr_q     <= 3'b111;
      vs_sr_q     <= 3'b111;
      vld_sr_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      wr_drop_q   <= wr_drop_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      pix_q       <= pix_d;
      hs_sr_q     <= hs_sr_d;
      vs_sr_q     <= vs_sr_d;
      vld_sr_q    <= vld_sr_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_ack    = wr_ack_q;
  assign wr_drop   = wr_drop_q;
  assign hsync     = hs_sr_q[2];
  assign vsync     = vs_sr_q[2];
  assign valid     = vld_sr_q[2];
  // pix_q holds the last fetched word for both the even and odd column.
  assign rgb       = vld_sr_q[2] ? pix_q : '0;
  assign arb_state = state_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: clock/reset, driver tasks, expected queues popped by
// a monitor process, final report.

module tb_fb_arbiter;

  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int AW   = 17;
  localparam int DW   = 12;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    h_cnt, v_cnt;
  logic          valid_in, hsync_in, vsync_in;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, wr_drop;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rgb;
  logic          hsync, vsync, valid;
  logic [1:0]    arb_state;

  fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW), .DW(DW)) dut (
    .pclk(pclk), .reset(reset),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .valid_in(valid_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_drop(wr_drop),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .valid(valid),
    .arb_state(arb_state)
  );

  // ---------------- clock / reset / memory stub ----------------
  always #5 pclk = ~pclk;

  int cyc = 0;  // posedges seen so far
  always @(posedge pclk) cyc <= cyc + 1;

  // Synchronous ROM: data = addr[11:0].
  always @(posedge pclk) mem_rdata <= mem_addr[11:0];

  // ---------------- scoreboard state ----------------
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            in_range;
  } wr_exp_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } rd_exp_t;

  logic [14:0] exp_q[$];   // {valid, hsync, vsync, rgb}
  wr_exp_t     wr_q[$];
  rd_exp_t     rd_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  bit exp_drop = 1'b0;
  int last_grant = -10;

  bit            cam_busy = 1'b0;
  logic [AW-1:0] cam_addr = '0;
  logic [DW-1:0] cam_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pix_of(input int h, input int v);
    int a;
    a = (v / 2) * FB_W + h / 2;
    return a[DW-1:0];
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic cam_set(input int addr, input int data);
    cam_busy = 1'b1;
    cam_addr = AW'(addr);
    cam_data = DW'(data);
  endtask

  task automatic cam_maybe(input int pct);
    if (!cam_busy && $urandom_range(99) < pct) begin
      if ($urandom_range(99) < 10) cam_set($urandom_range(131071, FB_W * FB_H), $urandom_range(4095));
      else                         cam_set($urandom_range(FB_W * FB_H - 1, 0), $urandom_range(4095));
    end
  endtask

  // Apply one cycle of inputs and record what the reference model expects.
  // A request is granted in any cycle that is not a fetch slot, unless a
  // grant was made in the immediately preceding cycle.
  task automatic drive(input int h, input int v, input bit vld, input bit hs, input bit vs);
    int      n;
    wr_exp_t we;
    rd_exp_t re;
    n        = cyc;
    h_cnt    = h[9:0];
    v_cnt    = v[9:0];
    valid_in = vld;
    hsync_in = hs;
    vsync_in = vs;
    wr_req   = cam_busy;
    wr_addr  = cam_addr;
    wr_data  = cam_data;
    exp_q.push_back({vld, hs, vs, vld ? pix_of(h, v) : 12'h000});
    if (vld && (h % 2 == 0)) begin
      re.cyc  = n + 1;
      re.addr = AW'((v / 2) * FB_W + h / 2);
      rd_q.push_back(re);
    end else if (cam_busy && last_grant != n - 1) begin
      we.cyc      = n + 1;
      we.addr     = cam_addr;
      we.data     = cam_data;
      we.in_range = (int'(cam_addr) < FB_W * FB_H);
      wr_q.push_back(we);
      last_grant  = n;
      cam_busy    = 1'b0;
    end
    @(negedge pclk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " mem_addr"},  mem_addr,  0);
    chk({tag, " mem_we"},    mem_we,    0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " wr_ack"},    wr_ack,    0);
    chk({tag, " wr_drop"},   wr_drop,   0);
    chk({tag, " rgb"},       rgb,       0);
    chk({tag, " valid"},     valid,     0);
    chk({tag, " hsync"},     hsync,     1);
    chk({tag, " vsync"},     vsync,     1);
  endtask

  // Called at a negedge with reset high: release and re-arm the model.
  task automatic reset_release();
    exp_q.delete();
    wr_q.delete();
    rd_q.delete();
    last_grant = -10;
    exp_drop   = 1'b0;
    // Delay line still shows reset values for the first two samples.
    exp_q.push_back({1'b0, 1'b1, 1'b1, 12'h000});
    exp_q.push_back({1'b0, 1'b1, 1'b1, 12'h000});
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [14:0] d_exp;
  wr_exp_t     w_exp;
  rd_exp_t     r_exp;

  always @(posedge pclk) begin
    #2;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("display queue underflow", 32'(exp_q.size()), 1);
      end else begin
        d_exp = exp_q.pop_front();
        chk("valid", valid, d_exp[14]);
        chk("hsync", hsync, d_exp[13]);
        chk("vsync", vsync, d_exp[12]);
        chk("rgb",   rgb,   d_exp[11:0]);
      end

      if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        r_exp = rd_q.pop_front();
        chk("fetch cycle", cyc, r_exp.cyc);
        chk("fetch mem_addr", mem_addr, r_exp.addr);
        chk("fetch mem_we", mem_we, 0);
      end

      if (wr_ack) begin
        if (wr_q.size() == 0 || wr_q[0].cyc > cyc) begin
          chk("unexpected wr_ack", wr_ack, 0);
        end else begin
          w_exp = wr_q.pop_front();
          chk("ack cycle", cyc, w_exp.cyc);
          chk("write mem_we", mem_we, w_exp.in_range);
          if (w_exp.in_range) begin
            chk("write mem_addr",  mem_addr,  w_exp.addr);
            chk("write mem_wdata", mem_wdata, w_exp.data);
          end else begin
            exp_drop = 1'b1;
          end
        end
      end else begin
        if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
          w_exp = wr_q.pop_front();
          chk("missing wr_ack", wr_ack, 1);
          if (!w_exp.in_range) exp_drop = 1'b1;
        end
        chk("mem_we without ack", mem_we, 0);
      end

      chk("wr_drop", wr_drop, exp_drop);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int v;
    h_cnt = '0; v_cnt = '0; valid_in = 0; hsync_in = 0; vsync_in = 0;
    wr_req = 0; wr_addr = '0; wr_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge pclk);
    check_reset_vals("reset");
    reset_release();

    // All inputs 0: syncs stay high 3 cycles, then follow the 0 inputs.
    repeat (5) drive(0, 0, 0, 0, 0);

    // Fetch on line 3, columns 0..5: addresses 320, 321, 322.
    for (int h = 0; h < 6; h++) drive(h, 3, 1, 1, 1);
    repeat (4) drive(0, 0, 0, 1, 1);

    // Blanking write, request re-raised during the ack: acks 2 cycles apart.
    cam_set(100, 12'hABC);
    drive(0, 0, 0, 1, 1);
    cam_set(100, 12'hABC);
    repeat (4) drive(0, 0, 0, 1, 1);

    // Write raised at an even active column waits for the odd one.
    for (int h = 0; h < 16; h++) begin
      if (h == 4) cam_set(7777, 12'h123);
      drive(h, 5, 1, 1, 1);
    end
    repeat (3) drive(0, 0, 0, 1, 1);

    // Boundary addresses: first out-of-range, then the last valid one.
    cam_set(FB_W * FB_H, 12'hFFF);
    repeat (3) drive(0, 0, 0, 1, 1);
    cam_set(FB_W * FB_H - 1, 12'h321);
    repeat (3) drive(0, 0, 0, 1, 1);

    // valid_in drops right after an even column.
    drive(0, 8, 1, 1, 1);
    drive(1, 8, 1, 1, 1);
    drive(2, 8, 1, 1, 1);
    drive(3, 8, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 1, 1);

    // Column wrap 639 -> 0 straight into the next line.
    drive(638, 9, 1, 1, 1);
    drive(639, 9, 1, 1, 1);
    drive(0, 10, 1, 1, 1);
    drive(1, 10, 1, 1, 1);
    repeat (3) drive(0, 0, 0, 1, 1);

    // Randomized lines with random camera traffic.
    for (int line = 0; line < 12; line++) begin
      v = $urandom_range(479);
      for (int h = 0; h < 640; h++) begin
        cam_maybe(40);
        drive(h, v, 1, 1, (line % 5) != 4);
      end
      for (int b = 0; b < 40; b++) begin
        cam_maybe(50);
        drive(0, v, 0, !(b >= 8 && b < 16), (line % 5) != 4);
      end
    end

    // Reset mid-line with a request pending behind a fetch slot.
    for (int h = 0; h < 10; h++) drive(h, 20, 1, 1, 1);
    cam_set(500, 12'h5A5);
    drive(10, 20, 1, 1, 1);
    @(posedge pclk);
    #3;
    reset  = 1'b1;
    mon_en = 1'b0;
    #1;
    check_reset_vals("async reset");
    @(negedge pclk);
    @(negedge pclk);
    reset_release();
    for (int h = 12; h < 20; h++) drive(h, 20, 1, 1, 1);

    cam_busy = 1'b0;
    repeat (6) drive(0, 0, 0, 1, 1);
    mon_en = 1'b0;
    chk("pending writes at end", 32'(wr_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
